// File: rtl/one_hot_rr_scheduler_if.sv
// Requester-side bundle for the one-hot round-robin scheduler: request/done in,
// grant/debug status out.
interface one_hot_rr_scheduler_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [3:0] state;

    modport master (
        output req,
        output done,
        input  grant,
        input  gnt_id,
        input  busy,
        input  timeout,
        input  state
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output gnt_id,
        output busy,
        output timeout,
        output state
    );
endinterface

// File: rtl/one_hot_rr_scheduler.sv
// Four-way round-robin scheduler for one shared resource; one-hot FSM
// IDLE -> ARB -> BUSY -> GAP with a hold limit and post-release idle gap.
module one_hot_rr_scheduler #(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    one_hot_rr_scheduler_if.slave sched
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ARB  = 4'b0010,
        S_BUSY = 4'b0100,
        S_GAP  = 4'b1000
    } state_e;

    // Held as raw bits so that a corrupted (non-one-hot) value is representable.
    logic [3:0]        r_state;
    logic [3:0]        r_grant;
    logic [1:0]        r_gnt_id;
    logic              r_busy;
    logic              r_timeout;
    logic [1:0]        r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic [GAP_W-1:0]  r_gap;

    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_owner_req;
    logic       w_expire;
    logic       w_release;

    // Search starts just past the last winner so it ends up with lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && sched.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_owner_req = sched.req[r_gnt_id];
    assign w_expire    = (r_hold == HOLD_LAST);
    assign w_release   = sched.done | ~w_owner_req | w_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'd3;
            r_hold    <= '0;
            r_gap     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|sched.req) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_state  <= S_BUSY;
                        r_grant  <= 4'(1) << w_win;
                        r_gnt_id <= w_win;
                        r_ptr    <= w_win;
                        r_busy   <= 1'b1;
                        r_hold   <= '0;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_state   <= S_GAP;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_gap     <= '0;
                        // Pulse only when the hold limit is the sole cause.
                        r_timeout <= w_expire & ~sched.done & w_owner_req;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= (|sched.req) ? S_ARB : S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sched.grant   = r_grant;
    assign sched.gnt_id  = r_gnt_id;
    assign sched.busy    = r_busy;
    assign sched.timeout = r_timeout;
    assign sched.state   = r_state;

endmodule

// File: tb/tb_one_hot_rr_scheduler.sv
// Directed bench for one_hot_rr_scheduler: stimulus pushes expected grant
// episodes, a negedge monitor pops and checks each one as it completes.
module tb_one_hot_rr_scheduler;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ARB  = 4'b0010;
    localparam logic [3:0] ST_BUSY = 4'b0100;
    localparam logic [3:0] ST_GAP  = 4'b1000;

    typedef struct {
        logic [1:0]  id;
        int unsigned len;
        logic        to;
    } ep_t;

    logic clk;
    logic reset;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    ep_t exp_q[$];

    logic        m_prev = 1'b0;
    logic [1:0]  m_id   = '0;
    logic [3:0]  m_grant = '0;
    int unsigned m_len  = 0;

    one_hot_rr_scheduler_if sif();

    one_hot_rr_scheduler #(
        .MAX_HOLD  (8),
        .GAP_CYCLES(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sched(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input int unsigned len, input logic to);
        ep_t e;
        e.id  = id;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic nxt(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: invariants every cycle, one scoreboard pop per finished grant.
    always @(negedge clk) begin
        ep_t e;
        logic [3:0] exp_grant;
        chk("inv_onehot", 32'($onehot0(sif.grant)), 32'd1);
        chk("inv_busy", 32'(sif.busy), 32'(|sif.grant));
        if (sif.grant != 4'b0000) chk("inv_state", 32'(sif.state), 32'(ST_BUSY));
        if (sif.busy && !m_prev) begin
            m_id    = sif.gnt_id;
            m_grant = sif.grant;
            m_len   = 1;
        end else if (sif.busy) begin
            m_len++;
            chk("grant_stable", 32'(sif.grant), 32'(m_grant));
        end else if (m_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ep_unexpected: got episode id %0d len %0d, expected none", m_id, m_len);
            end else begin
                e = exp_q.pop_front();
                exp_grant = 4'b0001 << e.id;
                chk("ep_id", 32'(m_id), 32'(e.id));
                chk("ep_grant", 32'(m_grant), 32'(exp_grant));
                chk("ep_len", m_len, e.len);
                chk("ep_timeout", 32'(sif.timeout), 32'(e.to));
            end
        end else begin
            chk("timeout_quiet", 32'(sif.timeout), 32'd0);
        end
        m_prev = sif.busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        sif.req  = 4'b1111;
        sif.done = 1'b0;

        // Reset held two cycles with all requests asserted
        nxt(1);
        chk("rst_state", 32'(sif.state), 32'(ST_IDLE));
        chk("rst_grant", 32'(sif.grant), 32'd0);
        chk("rst_timeout", 32'(sif.timeout), 32'd0);
        nxt(1);
        chk("rst_state2", 32'(sif.state), 32'(ST_IDLE));
        reset = 1'b0;
        nxt(1);
        chk("post_rst_arb", 32'(sif.state), 32'(ST_ARB));
        nxt(1);
        chk("post_rst_grant", 32'(sif.grant), 32'b0001);
        chk("post_rst_id", 32'(sif.gnt_id), 32'd0);

        // Round robin with done on the first BUSY cycle
        for (int k = 0; k < 5; k++) begin
            logic [1:0] id;
            id = 2'(k);
            push(id, 1, 1'b0);
            chk("rr_state", 32'(sif.state), 32'(ST_BUSY));
            chk("rr_id", 32'(sif.gnt_id), 32'(id));
            sif.done = 1'b1;
            nxt(1);
            sif.done = 1'b0;
            chk("rr_gap", 32'(sif.state), 32'(ST_GAP));
            if (k < 4) begin
                nxt(1);
                chk("rr_arb", 32'(sif.state), 32'(ST_ARB));
                nxt(1);
            end
        end
        sif.req = 4'b0000;
        nxt(1);
        chk("rr_idle", 32'(sif.state), 32'(ST_IDLE));

        // Single requester, done on third BUSY cycle
        sif.req = 4'b0100;
        push(2'd2, 3, 1'b0);
        nxt(1);
        chk("single_arb", 32'(sif.state), 32'(ST_ARB));
        nxt(1);
        chk("single_grant", 32'(sif.grant), 32'b0100);
        chk("single_id", 32'(sif.gnt_id), 32'd2);
        nxt(2);
        chk("single_busy3", 32'(sif.state), 32'(ST_BUSY));
        sif.done = 1'b1;
        sif.req  = 4'b0000;
        nxt(1);
        sif.done = 1'b0;
        chk("single_gap", 32'(sif.state), 32'(ST_GAP));
        nxt(1);
        chk("single_idle", 32'(sif.state), 32'(ST_IDLE));

        // Hold limit expiry, then re-grant and owner drop mid-BUSY
        sif.req = 4'b0010;
        push(2'd1, 8, 1'b1);
        nxt(2);
        chk("hold_grant", 32'(sif.grant), 32'b0010);
        nxt(7);
        chk("hold_busy8", 32'(sif.state), 32'(ST_BUSY));
        nxt(1);
        chk("hold_gap", 32'(sif.state), 32'(ST_GAP));
        chk("hold_timeout", 32'(sif.timeout), 32'd1);
        chk("hold_released", 32'(sif.grant), 32'd0);
        nxt(1);
        chk("hold_arb", 32'(sif.state), 32'(ST_ARB));
        chk("hold_to_off", 32'(sif.timeout), 32'd0);
        nxt(1);
        chk("regrant", 32'(sif.grant), 32'b0010);
        push(2'd1, 2, 1'b0);
        nxt(1);
        sif.req = 4'b0000;
        nxt(1);
        chk("drop_gap", 32'(sif.state), 32'(ST_GAP));
        chk("drop_timeout", 32'(sif.timeout), 32'd0);
        nxt(1);

        // done coinciding with hold expiry: no timeout pulse
        sif.req = 4'b1000;
        push(2'd3, 8, 1'b0);
        nxt(2);
        chk("exp_id", 32'(sif.gnt_id), 32'd3);
        nxt(7);
        sif.done = 1'b1;
        nxt(1);
        sif.done = 1'b0;
        sif.req  = 4'b0000;
        chk("exp_gap", 32'(sif.state), 32'(ST_GAP));
        chk("exp_timeout", 32'(sif.timeout), 32'd0);
        nxt(1);

        // Request withdrawn during ARB
        sif.req = 4'b0001;
        nxt(1);
        chk("wd_arb", 32'(sif.state), 32'(ST_ARB));
        sif.req = 4'b0000;
        nxt(1);
        chk("wd_idle", 32'(sif.state), 32'(ST_IDLE));
        chk("wd_grant", 32'(sif.grant), 32'd0);

        // Async reset during BUSY, then pointer restart check
        sif.req = 4'b0100;
        push(2'd2, 2, 1'b0);
        nxt(3);
        chk("mid_pre", 32'(sif.grant), 32'b0100);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(sif.grant), 32'd0);
        chk("mid_rst_busy", 32'(sif.busy), 32'd0);
        chk("mid_rst_state", 32'(sif.state), 32'(ST_IDLE));
        nxt(1);
        reset   = 1'b0;
        sif.req = 4'b1001;
        nxt(1);
        chk("mid_arb", 32'(sif.state), 32'(ST_ARB));
        nxt(1);
        chk("mid_restart_id", 32'(sif.gnt_id), 32'd0);
        chk("mid_restart_grant", 32'(sif.grant), 32'b0001);
        push(2'd0, 1, 1'b0);

        // Illegal state held across one edge
        #1 force dut.r_state = 4'b0110;
        nxt(1);
        sif.req = 4'b0000;
        release dut.r_state;
        chk("ill_grant", 32'(sif.grant), 32'd0);
        chk("ill_busy", 32'(sif.busy), 32'd0);
        nxt(1);
        chk("ill_state", 32'(sif.state), 32'(ST_IDLE));
        chk("ill_grant2", 32'(sif.grant), 32'd0);

        nxt(2);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/one_hot_rr_scheduler.md
Name: one_hot_rr_scheduler

Overview:
- Round-robin scheduler that shares one datapath resource among 4 requesters.
- Sequenced by a one-hot encoded FSM, which is exposed on `state` for debug and bench monitoring.
- Grants are one-hot and held until the owner signals `done`, drops its request, or exceeds a hold limit.
- Sits between the requesting blocks and the shared resource; `gnt_id` drives the resource's input mux select.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may remain in BUSY before forced release (>=2).
- GAP_CYCLES, 1, idle cycles inserted after each release before re-arbitration (>=1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  4  request lines, req[i] from requester i, level-sensitive
- done  input  1  owner signals transaction complete; sampled only in BUSY
- grant  output  4  one-hot grant, registered; 0000 when no owner
- gnt_id  output  2  binary index of current/last winner, registered
- busy  output  1  high while grant is nonzero
- timeout  output  1  one-cycle pulse when a grant is forcibly released at MAX_HOLD
- state  output  4  one-hot FSM state

Behaviour:
- State encoding: IDLE=0001, ARB=0010, BUSY=0100, GAP=1000.
- Reset values (async assert, clears immediately):
  - state=0001, grant=0000, gnt_id=00, busy=0, timeout=0.
  - Internal priority pointer ptr=3, so requester 0 wins first.
  - hold counter=0, gap counter=0.
- IDLE:
  - If req!=0 at a clock edge, go to ARB.
  - Otherwise stay in IDLE.
- ARB, single cycle:
  - Search req starting at (ptr+1) mod 4, wrapping upward; the first set bit wins.
  - On a win: next state BUSY; grant<=onehot(winner); gnt_id<=winner; ptr<=winner; hold counter<=0.
  - If req==0 in ARB (request withdrawn), return to IDLE with grant unchanged at 0000.
- Latency: req rises before edge E0 in IDLE, so ARB is active after E0 and grant is visible after E1 (2 cycles).
- BUSY:
  - grant is held constant and busy=1.
  - hold counter increments each cycle.
  - Release condition, evaluated each edge: done=1, OR req[gnt_id]=0, OR hold counter==MAX_HOLD-1.
  - On release: grant<=0000, busy<=0, next state GAP, gap counter<=0.
  - Maximum BUSY residency is MAX_HOLD cycles.
- timeout:
  - Pulses for 1 cycle, coincident with the first GAP cycle.
  - Asserted only when release was caused by the hold limit alone, i.e. done=0 and req[gnt_id]=1 on that edge.
  - If done or a request drop coincides with expiry, there is no timeout pulse.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - Then goes to ARB if req!=0, else IDLE.
  - A requester that just released may still win in ARB if no other request is pending (ptr already points at it, so it has lowest priority).
- gnt_id keeps the last winner value outside BUSY. Consumers qualify it with busy.
- done outside BUSY is ignored. Requests changing during GAP or IDLE have no effect until sampled in ARB.
- Non-one-hot state (e.g. SEU, forced value):
  - Next edge goes to IDLE with grant=0000 and busy=0.
  - ptr is unchanged.
- Reset asserted mid-BUSY: grant drops to 0000 asynchronously, with no timeout pulse. After reset release, arbitration restarts from requester 0.
- Invariants:
  - grant is always 0000 or one-hot.
  - grant!=0 only in BUSY.
  - busy == |grant.

Test Plan:
- Reset: assert reset for 2 cycles, with req=1111 held throughout.
  - During reset: state=0001, grant=0000, timeout=0.
  - After release: ARB after 1 edge, then grant=0001, gnt_id=00.
- Single requester: req=0100 from IDLE, done pulsed on the 3rd BUSY cycle.
  - Required sequence: state 0001 -> 0010 -> 0100 (grant=0100, gnt_id=10 for 3 cycles) -> 1000 -> 0001 (after req drops).
  - timeout never asserts.
- Round-robin fairness: req=1111 held, done pulsed on the 1st BUSY cycle each time.
  - Successive gnt_id must be 00, 01, 10, 11, 00.
  - Each grant lasts 1 cycle and is separated by GAP (1 cycle) plus ARB (1 cycle).
- Hold timeout: req=0010 held, done=0, MAX_HOLD=8.
  - grant=0010 for exactly 8 cycles, then 0000.
  - timeout=1 for exactly one cycle, coincident with state=1000.
  - Re-grant to requester 1 follows after ARB.
- Request drop / simultaneous events:
  - Owner drops req mid-BUSY: release on the next edge, timeout=0.
  - Separate run: done=1 on the exact expiry cycle must give timeout=0.
  - Separate run: req withdrawn in the ARB cycle returns to IDLE with grant=0000.
- Reset mid-operation and illegal state:
  - Assert reset during BUSY: grant=0000 immediately (before the next edge).
  - Force state=0110 for one cycle, then release the force: the next state is 0001 and grant=0000.
